// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus (CDB) arbiter.
//   cdb_req_t : one execution unit's write-back result (valid, rd_addr, rob_idx, data)
//   cdb_t     : the broadcast seen by the ROB, reservation stations and rename logic
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ   = 4;   // 0=ALU, 1=MUL, 2=DIV, 3=LSU
  localparam int CDB_ROB_IDX_W = 5;   // ROB depth 32
  localparam int CDB_REG_W     = 5;
  localparam int CDB_DATA_W    = 32;

  typedef struct packed {
    logic                     valid;
    logic [CDB_REG_W-1:0]     rd_addr;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_DATA_W-1:0]    data;
  } cdb_req_t;

  typedef struct packed {
    logic                     valid;
    logic [CDB_REG_W-1:0]     rd_addr;
    logic [CDB_ROB_IDX_W-1:0] rob_idx;
    logic [CDB_DATA_W-1:0]    data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per requester
//   ptr   : index that has first claim this cycle
//   grant : one-hot grant of the first requester found scanning ptr, ptr+1, ... (wrapping),
//           or zero when nothing requests
module cdb_arbiter_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks at most one execution-unit result per cycle and drives it onto a
// registered broadcast bus. Priority: starved unit, then the result for the ROB head,
// then round-robin among the rest.
//   clk, rst      : clock; asynchronous active-low reset
//   req_i         : per-unit result (valid, rd_addr, rob_idx, data)
//   req_ready_o   : per-unit one-hot grant (combinational); transfer on valid && ready
//   rob_head_i    : current ROB head index
//   flush_i       : kills this cycle's arbitration and clears fairness state
//   cdbus         : registered broadcast, valid for exactly one cycle per grant
//   starve_flag_o : per-unit, high while its wait counter has reached STARVE_LIM
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = CDB_NUM_REQ,
  parameter int STARVE_LIM = 8,
  parameter int ROB_IDX_W  = CDB_ROB_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  cdb_req_t             req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [ROB_IDX_W-1:0] rob_head_i,
  input  logic                 flush_i,
  output cdb_t                 cdbus,
  output logic [NUM_REQ-1:0]   starve_flag_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] starved_vec;
  logic [NUM_REQ-1:0] head_vec;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] grant;
  logic               rr_win;
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   win_idx;
  cdb_req_t           win_req;

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unit
      logic [CNT_W-1:0] wait_cnt_reg;

      assign valid_vec[gi]     = req_i[gi].valid;
      assign starve_flag_o[gi] = (wait_cnt_reg >= CNT_W'(STARVE_LIM));
      assign starved_vec[gi]   = valid_vec[gi] && starve_flag_o[gi];
      assign head_vec[gi]      = valid_vec[gi] && (req_i[gi].rob_idx == rob_head_i);

      // Counts consecutive denied cycles; any idle cycle or grant restarts the count.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wait_cnt_reg <= '0;
        end else if (flush_i || !valid_vec[gi] || grant[gi]) begin
          wait_cnt_reg <= '0;
        end else if (wait_cnt_reg < CNT_W'(STARVE_LIM)) begin
          wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
      end

      // Stimulus sanity: a waiting result must not change under the arbiter.
      assert property (@(posedge clk) disable iff (!rst)
        (req_i[gi].valid && !req_ready_o[gi] && !flush_i) |=> (req_i[gi] == $past(req_i[gi])));

      for (gj = gi + 1; gj < NUM_REQ; gj++) begin : g_pair
        assert property (@(posedge clk) disable iff (!rst)
          !(req_i[gi].valid && req_i[gj].valid && (req_i[gi].rob_idx == req_i[gj].rob_idx)));
      end
    end
  endgenerate

  cdb_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_picker (
    .req   (valid_vec),
    .ptr   (rr_ptr_reg),
    .grant (rr_grant)
  );

  // Ready is forced low while in reset so nothing is handed over during that window.
  always_comb begin
    grant  = '0;
    rr_win = 1'b0;
    if (rst && !flush_i) begin
      if (|starved_vec) begin
        grant = lowest_one(starved_vec);
      end else if (|head_vec) begin
        grant = lowest_one(head_vec);
      end else begin
        grant  = rr_grant;
        rr_win = |rr_grant;
      end
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = PTR_W'(i);
    end
    win_req = req_i[win_idx];
  end

  // Only a round-robin win moves the pointer; override grants must not disturb fairness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
    end else if (flush_i) begin
      rr_ptr_reg <= '0;
    end else if (rr_win) begin
      rr_ptr_reg <= PTR_W'((int'(win_idx) + 1) % NUM_REQ);
    end
  end

  // Payload fields hold between grants; only valid pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdbus <= '0;
    end else begin
      cdbus.valid <= |grant;
      if (|grant) begin
        cdbus.rd_addr <= win_req.rd_addr;
        cdbus.rob_idx <= win_req.rob_idx;
        cdbus.data    <= win_req.data;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst;
  cdb_req_t      req [N];
  logic [N-1:0]  ready;
  logic [4:0]    rob_head;
  logic          flush;
  cdb_t          cdbus;
  logic [N-1:0]  starve;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_wait [N];
  int   m_ptr;
  cdb_t m_cdb;
  bit   m_rule3;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .STARVE_LIM(LIM), .ROB_IDX_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .req_ready_o   (ready),
    .rob_head_i    (rob_head),
    .flush_i       (flush),
    .cdbus         (cdbus),
    .starve_flag_o (starve)
  );

  function automatic int model_pick();
    m_rule3 = 0;
    if (!rst || flush) return -1;
    for (int k = 0; k < N; k++)
      if (req[k].valid && m_wait[k] >= LIM) return k;
    for (int k = 0; k < N; k++)
      if (req[k].valid && req[k].rob_idx == rob_head) return k;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req[k].valid) begin
        m_rule3 = 1;
        return k;
      end
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [N-1:0] model_starve();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (m_wait[k] >= LIM);
    return r;
  endfunction

  function automatic void model_commit(int w);
    if (flush) begin
      for (int k = 0; k < N; k++) m_wait[k] = 0;
      m_ptr = 0;
      m_cdb.valid = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      if (!req[k].valid || k == w) m_wait[k] = 0;
      else if (m_wait[k] < LIM) m_wait[k]++;
    end
    m_cdb.valid = (w >= 0);
    if (w >= 0) begin
      m_cdb.rd_addr = req[w].rd_addr;
      m_cdb.rob_idx = req[w].rob_idx;
      m_cdb.data    = req[w].data;
    end
    if (m_rule3) m_ptr = (w + 1) % N;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_wait[k] = 0;
    m_ptr = 0;
    m_cdb = '0;
  endfunction

  // New result for unit k with a rob_idx unused by any other valid unit (31 never used).
  function automatic void fresh(int k);
    logic [4:0] r;
    bit clash;
    do begin
      r = 5'($urandom_range(0, 30));
      clash = 0;
      for (int j = 0; j < N; j++)
        if (j != k && req[j].valid && req[j].rob_idx == r) clash = 1;
    end while (clash);
    req[k].valid   = 1'b1;
    req[k].rob_idx = r;
    req[k].rd_addr = 5'($urandom);
    req[k].data    = $urandom;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < N; k++) req[k] = '0;
    flush = 1'b0;
    rob_head = 5'd31;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b0;
    flush = 1'b0;
    rob_head = 5'd31;
    for (int k = 0; k < N; k++) begin
      req[k].valid   = 1'b1;
      req[k].rob_idx = 5'(10 + k);
      req[k].rd_addr = 5'(k + 1);
      req[k].data    = 32'h1000 + k;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", ready); end
    checks++;
    if (cdbus !== cdb_t'('0)) begin errors++; $display("FAIL reset_cdbus got=%h exp=0", cdbus); end
    checks++;
    if (starve !== 4'b0000) begin errors++; $display("FAIL reset_starve got=%b exp=0000", starve); end
    $display("reset held: ready=%b cdbus.valid=%b", ready, cdbus.valid);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    w = model_pick();
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got=%b exp=0001", ready); end
    $display("reset release cycle1: ready=%b", ready);
    model_commit(w);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdbus.valid !== 1'b1 || cdbus.rob_idx !== 5'd10) begin
      errors++; $display("FAIL reset_first_bcast got=%b/%0d exp=1/10", cdbus.valid, cdbus.rob_idx);
    end
    $display("reset release cycle2: cdbus valid=%b rob=%0d", cdbus.valid, cdbus.rob_idx);
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 3, 0, 1, 3};
    int w;
    logic [N-1:0] seen;
    apply_reset();
    fresh(0); fresh(1); fresh(3);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      w = model_pick();
      if (c < 6) begin
        checks++;
        if (ready !== onehot(order[c])) begin
          errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, ready, onehot(order[c]));
        end
      end
      checks++;
      if (cdbus !== m_cdb) begin errors++; $display("FAIL rr_cdbus c=%0d got=%h exp=%h", c, cdbus, m_cdb); end
      $display("rr c=%0d ready=%b cdbus=%h", c, ready, cdbus);
      seen = ready;
      model_commit(w);
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (seen[k]) fresh(k);
    end
  endtask

  task automatic test_head();
    int w;
    apply_reset();
    req[0] = '{valid: 1'b1, rd_addr: 5'd1, rob_idx: 5'd7, data: 32'hA0A0_0007};
    req[2] = '{valid: 1'b1, rd_addr: 5'd2, rob_idx: 5'd4, data: 32'hD1D1_0004};
    rob_head = 5'd4;
    @(negedge clk);
    w = model_pick();
    checks++;
    if (ready !== 4'b0100) begin errors++; $display("FAIL head_grant got=%b exp=0100", ready); end
    $display("head c=0 ready=%b", ready);
    model_commit(w);
    @(posedge clk); #1;
    req[2].valid = 1'b0;
    @(negedge clk);
    w = model_pick();
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL head_ptr_kept got=%b exp=0001", ready); end
    checks++;
    if (cdbus.valid !== 1'b1 || cdbus.rob_idx !== 5'd4 || cdbus.data !== 32'hD1D1_0004) begin
      errors++; $display("FAIL head_bcast got=%h exp rob=4 data=d1d10004", cdbus);
    end
    $display("head c=1 ready=%b cdbus=%h", ready, cdbus);
    model_commit(w);
    @(posedge clk); #1;
    req[0].valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cdbus.valid !== 1'b1 || cdbus.rob_idx !== 5'd7) begin
      errors++; $display("FAIL head_next_bcast got=%b/%0d exp=1/7", cdbus.valid, cdbus.rob_idx);
    end
    $display("head c=2 cdbus=%h", cdbus);
  endtask

  task automatic test_starvation();
    int w;
    logic [N-1:0] seen;
    apply_reset();
    fresh(1); fresh(3);
    rob_head = req[1].rob_idx;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      w = model_pick();
      checks++;
      if (ready !== onehot(w)) begin errors++; $display("FAIL starve_ready c=%0d got=%b exp=%b", c, ready, onehot(w)); end
      checks++;
      if (starve !== model_starve()) begin
        errors++; $display("FAIL starve_flag c=%0d got=%b exp=%b", c, starve, model_starve());
      end
      if (c == 9) begin
        checks++;
        if (ready !== 4'b1000 || starve[3] !== 1'b1) begin
          errors++; $display("FAIL starve_promote got ready=%b flag=%b exp 1000/1", ready, starve[3]);
        end
      end
      $display("starve c=%0d ready=%b flags=%b", c, ready, starve);
      seen = ready;
      model_commit(w);
      @(posedge clk); #1;
      if (seen[1]) fresh(1);
      if (seen[3]) fresh(3);
      rob_head = req[1].rob_idx;
    end
  endtask

  task automatic test_flush();
    int w;
    logic [N-1:0] seen;
    apply_reset();
    fresh(0); fresh(2);
    @(negedge clk);
    w = model_pick();
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL flush_pre got=%b exp=0001", ready); end
    seen = ready;
    model_commit(w);
    @(posedge clk); #1;
    if (seen[0]) fresh(0);
    flush = 1'b1;
    @(negedge clk);
    w = model_pick();
    checks++;
    if (ready !== 4'b0000) begin errors++; $display("FAIL flush_ready got=%b exp=0000", ready); end
    checks++;
    if (cdbus.valid !== 1'b1) begin errors++; $display("FAIL flush_no_retract got=%b exp=1", cdbus.valid); end
    $display("flush c=1 ready=%b cdbus.valid=%b", ready, cdbus.valid);
    model_commit(w);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    w = model_pick();
    checks++;
    if (cdbus.valid !== 1'b0) begin errors++; $display("FAIL flush_bcast got=%b exp=0", cdbus.valid); end
    checks++;
    if (ready !== 4'b0001) begin errors++; $display("FAIL flush_resume got=%b exp=0001", ready); end
    $display("flush c=2 ready=%b cdbus.valid=%b", ready, cdbus.valid);
    model_commit(w);
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    int w, hits;
    logic [4:0] mul_rob;
    logic [31:0] got_data;
    logic [N-1:0] seen;
    hits = 0;
    got_data = '0;
    apply_reset();
    fresh(1);
    req[1].data = 32'hDEADBEEF;
    mul_rob = req[1].rob_idx;
    fresh(0);
    rob_head = req[0].rob_idx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      w = model_pick();
      checks++;
      if (ready !== onehot(w)) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, ready, onehot(w)); end
      if (c == 4) begin
        checks++;
        if (ready !== 4'b0010) begin errors++; $display("FAIL bp_mul_grant got=%b exp=0010", ready); end
      end
      if (cdbus.valid && cdbus.rob_idx == mul_rob) begin
        hits++;
        got_data = cdbus.data;
      end
      $display("bp c=%0d ready=%b cdbus=%h", c, ready, cdbus);
      seen = ready;
      model_commit(w);
      @(posedge clk); #1;
      if (seen[0]) begin
        if (c < 3) begin
          fresh(0);
          rob_head = req[0].rob_idx;
        end else begin
          req[0].valid = 1'b0;
          rob_head = 5'd31;
        end
      end
      if (seen[1]) req[1].valid = 1'b0;
    end
    checks++;
    if (hits != 1) begin errors++; $display("FAIL bp_once got=%0d exp=1", hits); end
    checks++;
    if (got_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_data got=%h exp=deadbeef", got_data); end
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] seen;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      w = model_pick();
      checks++;
      if (ready !== onehot(w)) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, ready, onehot(w)); end
      checks++;
      if (cdbus !== m_cdb) begin errors++; $display("FAIL rand_cdbus c=%0d got=%h exp=%h", c, cdbus, m_cdb); end
      checks++;
      if (starve !== model_starve()) begin
        errors++; $display("FAIL rand_starve c=%0d got=%b exp=%b", c, starve, model_starve());
      end
      $display("rand c=%0d flush=%b head=%0d ready=%b cdbus=%h", c, flush, rob_head, ready, cdbus);
      seen = ready;
      model_commit(w);
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (req[k].valid && seen[k]) begin
          if ($urandom_range(0, 1) == 0) fresh(k);
          else req[k].valid = 1'b0;
        end else if (!req[k].valid && $urandom_range(0, 2) == 0) begin
          fresh(k);
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 0) rob_head = req[$urandom_range(0, N - 1)].rob_idx;
      else rob_head = 5'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_head();
    test_starvation();
    test_flush();
    test_back_pressure();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
